// File: rtl/exe_mem_skid_reg_pkg.sv
// Shared types for the EX/MEM skid register: occupancy states, the slot
// entry layout and the bit positions of the {N,Z,C,V} flags.
package exe_mem_skid_reg_pkg;

    // Occupancy of the two-entry skid register.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // One instruction's worth of EX results carried into MEM.
    typedef struct packed {
        logic [31:0] result;
        logic [31:0] val_rm;
        logic [3:0]  dest;
        logic        wb_en;
        logic        mem_r_en;
        logic        mem_w_en;
    } entry_t;

    // Flag bit positions within status / in_sr.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Bundles the individual EX-side fields into one slot entry.
    function automatic entry_t make_entry(
        input logic [31:0] result,
        input logic [31:0] val_rm,
        input logic [3:0]  dest,
        input logic        wb_en,
        input logic        mem_r_en,
        input logic        mem_w_en
    );
        entry_t e;
        e.result   = result;
        e.val_rm   = val_rm;
        e.dest     = dest;
        e.wb_en    = wb_en;
        e.mem_r_en = mem_r_en;
        e.mem_w_en = mem_w_en;
        return e;
    endfunction

endpackage

// File: rtl/exe_mem_skid_reg_status_reg.sv
// Architectural {N,Z,C,V} status register: 4-bit, load-enable, synchronous
// active-high reset. Never touched by flush, so flags from instructions that
// were accepted before a squash survive it.
module exe_mem_skid_reg_status_reg
    import exe_mem_skid_reg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] d,
    output logic [3:0] q
);

    // Capture new flags on load, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 4'b0000;
        end else if (load) begin
            q[FLAG_N] <= d[FLAG_N];
            q[FLAG_Z] <= d[FLAG_Z];
            q[FLAG_C] <= d[FLAG_C];
            q[FLAG_V] <= d[FLAG_V];
        end
    end

endmodule

// File: rtl/exe_mem_skid_reg.sv
// EX/MEM pipeline register with a one-entry skid buffer so that in_ready can
// be a pure register (no combinational path from out_ready).
// Optional macro: EXE_MEM_FWD_EN adds fwd_wb_en / fwd_dest / fwd_data
// forwarding outputs driven from the main slot.
//
// state | meaning
// ------+--------------------------------------------------------------
// EMPTY | no entry held; out_valid=0, in_ready=1
// ONE   | main slot holds the oldest entry; in_ready=1
// TWO   | main holds oldest, skid holds the next one; in_ready=0
module exe_mem_skid_reg
    import exe_mem_skid_reg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_result,
    input  logic [31:0] in_val_rm,
    input  logic [3:0]  in_dest,
    input  logic        in_wb_en,
    input  logic        in_mem_r_en,
    input  logic        in_mem_w_en,
    input  logic        in_s,
    input  logic [3:0]  in_sr,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [31:0] out_val_rm,
    output logic [3:0]  out_dest,
    output logic        out_wb_en,
    output logic        out_mem_r_en,
    output logic        out_mem_w_en,
`ifdef EXE_MEM_FWD_EN
    output logic        fwd_wb_en,
    output logic [3:0]  fwd_dest,
    output logic [31:0] fwd_data,
`endif
    output logic [3:0]  status
);

    state_t state;
    entry_t main_slot;
    entry_t skid_slot;
    entry_t in_entry;
    logic   in_xfer;
    logic   out_xfer;

    assign in_entry = make_entry(in_result, in_val_rm, in_dest,
                                 in_wb_en, in_mem_r_en, in_mem_w_en);

    // Handshakes; flush blocks acceptance of the instruction presented with it.
    assign in_xfer  = in_valid && in_ready && !flush;
    assign out_xfer = out_valid && out_ready;

    // Occupancy FSM with registered in_ready/out_valid; slots written only on a load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            main_slot <= '0;
            skid_slot <= '0;
        end else if (flush) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        main_slot <= in_entry;
                        state     <= ONE;
                        out_valid <= 1'b1;
                        in_ready  <= 1'b1;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_slot <= in_entry;
                    end else if (in_xfer) begin
                        skid_slot <= in_entry;
                        state     <= TWO;
                        in_ready  <= 1'b0;
                    end else if (out_xfer) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        main_slot <= skid_slot;
                        state     <= ONE;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Data comes straight from the main slot; control bits are masked so a
    // stale entry left behind by a drain or flush never looks live.
    assign out_result   = main_slot.result;
    assign out_val_rm   = main_slot.val_rm;
    assign out_dest     = main_slot.dest;
    assign out_wb_en    = out_valid && main_slot.wb_en;
    assign out_mem_r_en = out_valid && main_slot.mem_r_en;
    assign out_mem_w_en = out_valid && main_slot.mem_w_en;

`ifdef EXE_MEM_FWD_EN
    // Forwarding view of the entry currently headed into MEM.
    assign fwd_wb_en = out_valid && main_slot.wb_en;
    assign fwd_dest  = main_slot.dest;
    assign fwd_data  = main_slot.result;
`endif

    exe_mem_skid_reg_status_reg u_status_reg (
        .clk  (clk),
        .rst  (rst),
        .load (in_xfer && in_s),
        .d    (in_sr),
        .q    (status)
    );

endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// Directed bench for exe_mem_skid_reg: inputs change 1 ns after a rising
// edge and outputs are checked at that same point, away from the edge.
module tb_exe_mem_skid_reg;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        in_valid, in_ready;
    logic [31:0] in_result, in_val_rm;
    logic [3:0]  in_dest;
    logic        in_wb_en, in_mem_r_en, in_mem_w_en, in_s;
    logic [3:0]  in_sr;
    logic        out_valid, out_ready;
    logic [31:0] out_result, out_val_rm;
    logic [3:0]  out_dest;
    logic        out_wb_en, out_mem_r_en, out_mem_w_en;
    logic [3:0]  status;
`ifdef EXE_MEM_FWD_EN
    logic        fwd_wb_en;
    logic [3:0]  fwd_dest;
    logic [31:0] fwd_data;
`endif

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    exe_mem_skid_reg dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_val_rm    (in_val_rm),
        .in_dest      (in_dest),
        .in_wb_en     (in_wb_en),
        .in_mem_r_en  (in_mem_r_en),
        .in_mem_w_en  (in_mem_w_en),
        .in_s         (in_s),
        .in_sr        (in_sr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_val_rm   (out_val_rm),
        .out_dest     (out_dest),
        .out_wb_en    (out_wb_en),
        .out_mem_r_en (out_mem_r_en),
        .out_mem_w_en (out_mem_w_en),
`ifdef EXE_MEM_FWD_EN
        .fwd_wb_en    (fwd_wb_en),
        .fwd_dest     (fwd_dest),
        .fwd_data     (fwd_data),
`endif
        .status       (status)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] res, input logic [3:0] dst,
                          input logic wb, input logic mw, input logic s, input logic [3:0] sr);
        in_valid    = v;
        in_result   = res;
        in_val_rm   = ~res;
        in_dest     = dst;
        in_wb_en    = wb;
        in_mem_r_en = 1'b0;
        in_mem_w_en = mw;
        in_s        = s;
        in_sr       = sr;
    endtask

    logic [31:0] got [$];
    int          idx;
    logic        xfer_seen;

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        set_in(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        step();
        check("rst_in_ready",   32'(in_ready),   32'd1);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_status",     32'(status),     32'd0);
        check("rst_out_result", out_result,      32'd0);
        check("rst_out_wb_en",  32'(out_wb_en),  32'd0);

        // Single entry, 1-cycle latency, then drained.
        rst = 1'b0; out_ready = 1'b1;
        set_in(1'b1, 32'h10, 4'd3, 1'b1, 1'b0, 1'b0, 4'h0);
        step();
        check("one_out_valid",  32'(out_valid),  32'd1);
        check("one_out_result", out_result,      32'h10);
        check("one_out_dest",   32'(out_dest),   32'd3);
        check("one_out_wb_en",  32'(out_wb_en),  32'd1);
        check("one_out_val_rm", out_val_rm,      ~32'h10);
        in_valid = 1'b0;
        step();
        check("one_drained",    32'(out_valid),  32'd0);
        check("one_wb_masked",  32'(out_wb_en),  32'd0);

        // Fill to TWO under back-pressure, then drain in order.
        out_ready = 1'b0;
        set_in(1'b1, 32'hA, 4'd1, 1'b1, 1'b0, 1'b0, 4'h0);
        step();
        check("fill_a_ready",   32'(in_ready),   32'd1);
        set_in(1'b1, 32'hB, 4'd5, 1'b0, 1'b1, 1'b0, 4'h0);
        step();
        check("two_in_ready",   32'(in_ready),   32'd0);
        check("two_out_valid",  32'(out_valid),  32'd1);
        check("two_head_a",     out_result,      32'hA);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("drain_b",        out_result,      32'hB);
        check("drain_b_dest",   32'(out_dest),   32'd5);
        check("drain_b_mem_w",  32'(out_mem_w_en), 32'd1);
        check("drain_b_wb",     32'(out_wb_en),  32'd0);
        check("drain_ready",    32'(in_ready),   32'd1);
        step();
        check("drain_empty",    32'(out_valid),  32'd0);
        check("drain_mem_w_0",  32'(out_mem_w_en), 32'd0);

        // Stream 1..8 with out_ready toggling every cycle.
        idx = 1;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 60 && got.size() < 8; cyc++) begin
            out_ready = ~out_ready;
            set_in(idx <= 8, 32'(idx), 4'd2, 1'b1, 1'b0, 1'b0, 4'h0);
            xfer_seen = out_valid && out_ready;
            if (xfer_seen) got.push_back(out_result);
            if (in_valid && in_ready) idx++;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("stream_count",   32'(got.size()), 32'd8);
        for (int i = 0; i < got.size() && i < 8; i++)
            check($sformatf("stream_order_%0d", i), got[i], 32'(i + 1));
        check("stream_no_extra", 32'(out_valid), 32'd0);

        // Flush in TWO with out_ready high: nothing delivered.
        out_ready = 1'b0;
        set_in(1'b1, 32'h21, 4'd1, 1'b1, 1'b0, 1'b0, 4'h0);
        step();
        set_in(1'b1, 32'h22, 4'd1, 1'b1, 1'b0, 1'b0, 4'h0);
        step();
        check("flush_pre_two",  32'(in_ready),   32'd0);
        flush = 1'b1; out_ready = 1'b1;
        set_in(1'b1, 32'h23, 4'd1, 1'b1, 1'b0, 1'b0, 4'h0);
        step();
        check("flush_valid",    32'(out_valid),  32'd0);
        check("flush_ready",    32'(in_ready),   32'd1);
        check("flush_wb_mask",  32'(out_wb_en),  32'd0);
        flush = 1'b0; in_valid = 1'b0;
        step();
        check("flush_no_deliv", 32'(out_valid),  32'd0);

        // Status load / hold / survive flush.
        out_ready = 1'b1;
        set_in(1'b1, 32'h30, 4'd1, 1'b0, 1'b0, 1'b1, 4'b0110);
        step();
        check("status_load",    32'(status),     32'b0110);
        set_in(1'b1, 32'h31, 4'd1, 1'b0, 1'b0, 1'b0, 4'b1001);
        step();
        check("status_s0_hold", 32'(status),     32'b0110);
        flush = 1'b1;
        set_in(1'b1, 32'h32, 4'd1, 1'b0, 1'b0, 1'b1, 4'b1111);
        step();
        check("status_flush",   32'(status),     32'b0110);
        flush = 1'b0; in_valid = 1'b0;
        step();

        // Fill to TWO; a blocked in_s=1 instruction must not touch status.
        out_ready = 1'b0;
        set_in(1'b1, 32'h41, 4'd7, 1'b1, 1'b0, 1'b0, 4'h0);
        step();
        set_in(1'b1, 32'h42, 4'd7, 1'b1, 1'b0, 1'b0, 4'h0);
        step();
        set_in(1'b1, 32'h43, 4'd7, 1'b1, 1'b0, 1'b1, 4'b1111);
        step();
        check("blocked_status", 32'(status),     32'b0110);
        check("blocked_head",   out_result,      32'h41);

        // Reset in TWO with in_valid high drops everything.
        rst = 1'b1;
        step();
        check("rst2_valid",     32'(out_valid),  32'd0);
        check("rst2_status",    32'(status),     32'd0);
        check("rst2_ready",     32'(in_ready),   32'd1);
        check("rst2_result",    out_result,      32'd0);
        check("rst2_dest",      32'(out_dest),   32'd0);
`ifdef EXE_MEM_FWD_EN
        check("rst2_fwd_wb",    32'(fwd_wb_en),  32'd0);
`endif
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("rst2_no_deliv",  32'(out_valid),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
